// File: rtl/receive_and_decrypt.sv
// +----------------------------------------------------------------------------+
// | receive_and_decrypt: serial XOR-decrypting receiver into a 16-word buffer   |
// | Optional: `define SHORT_FRAME_CHK_EN enables the sticky short-frame flag     |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module receive_and_decrypt #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena_in,
  input  logic              data_enc,
  input  logic              key,
  input  logic [ADDR_W-1:0] addr_rd,
  output logic [DATA_W-1:0] data_rd,
  output logic              busy,
  output logic              frame_done,
  output logic              err
);

  localparam int CNT_W = ADDR_W + 2;
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-2:0] shift_q, shift_d;
  logic              frame_done_q, frame_done_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              w_bit;
  logic              w_wr_en;
  logic [ADDR_W-1:0] w_wr_idx;
  logic [DATA_W-1:0] w_wr_data;

  assign w_bit     = data_enc ^ key;
  assign w_wr_idx  = cnt_q[CNT_W-1:2];
  assign w_wr_data = {shift_q, w_bit};

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    frame_done_d = 1'b0;
    w_wr_en      = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (ena_in) begin
          shift_d = {shift_q[DATA_W-3:0], w_bit};
          cnt_d   = CNT_W'(1);
          state_d = RECV;
        end
      end
      RECV: begin
        if (ena_in) begin
          shift_d = {shift_q[DATA_W-3:0], w_bit};
          cnt_d   = cnt_q + CNT_W'(1);
          // Last bit of each word completes it; write on this same edge.
          w_wr_en = (cnt_q[1:0] == 2'b11);
          if (&cnt_q) begin
            frame_done_d = 1'b1;
            cnt_d        = '0;
            state_d      = HOLD;
          end
        end else begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      HOLD: begin
        cnt_d = '0;
        if (!ena_in) state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      shift_q      <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (w_wr_en) begin
      mem_q[w_wr_idx] <= w_wr_data;
    end
  end

  assign data_rd    = mem_q[addr_rd];
  assign busy       = (state_q == RECV);
  assign frame_done = frame_done_q;

`ifdef SHORT_FRAME_CHK_EN
  logic err_q, err_d;

  // Cleared on the edge that completes a frame, so it falls with frame_done rising.
  always_comb begin
    err_d = err_q;
    if (frame_done_d) err_d = 1'b0;
    else if (state_q == RECV && !ena_in) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_receive_and_decrypt.sv
// Directed table-driven bench for receive_and_decrypt.
`default_nettype none

module tb_receive_and_decrypt;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena_in;
  logic       data_enc;
  logic       key;
  logic [3:0] addr_rd;
  logic [3:0] data_rd;
  logic       busy;
  logic       frame_done;
  logic       err;

`ifdef SHORT_FRAME_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  receive_and_decrypt #(.DATA_W(4), .ADDR_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena_in     (ena_in),
    .data_enc   (data_enc),
    .key        (key),
    .addr_rd    (addr_rd),
    .data_rd    (data_rd),
    .busy       (busy),
    .frame_done (frame_done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  always @(negedge clk) if (frame_done) done_cnt++;

  typedef struct {
    logic        key;
    logic [63:0] plain;
    int          nbits;
    logic [63:0] exp_mem;
    int          exp_done;
    logic        exp_err;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_mem(input string name, input logic [63:0] exp);
    for (int i = 0; i < 16; i++) begin
      addr_rd = 4'(i);
      #1;
      check($sformatf("%s word%0d", name, i), 64'(data_rd), 64'(exp[63-4*i -: 4]));
    end
    addr_rd = 4'd0;
  endtask

  // Drives n bits of the plain stream (encrypted with k); bits past 64 are filler.
  task automatic send(input logic k, input logic [63:0] plain, input int n);
    logic [3:0] w0;
    w0 = plain[63:60];
    addr_rd = 4'd0;
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      if (j == 4) check("word0 visible after write", 64'(data_rd), 64'(w0));
      if (j == 70) begin
        check("busy low in HOLD", 64'(busy), 64'd0);
        check("single done while held", 64'(done_cnt), 64'd1);
      end
      ena_in   = 1'b1;
      key      = k;
      data_enc = ((j < 64) ? plain[63-j] : 1'b1) ^ k;
    end
    @(negedge clk);
    ena_in   = 1'b0;
    data_enc = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{1'b0, 64'h0123456789ABCDEF, 64, 64'h0123456789ABCDEF, 1, 1'b0};
    vecs[1] = '{1'b1, 64'hAAAAAAAAAAAAAAAA, 64, 64'hAAAAAAAAAAAAAAAA, 1, 1'b0};
    vecs[2] = '{1'b0, 64'h5555555555555555, 10, 64'h55AAAAAAAAAAAAAA, 0, CHK};
    vecs[3] = '{1'b1, 64'hFEDCBA9876543210, 80, 64'hFEDCBA9876543210, 1, 1'b0};

    rst_n = 1'b0; ena_in = 1'b0; data_enc = 1'b0; key = 1'b0; addr_rd = 4'd0;
    #12;
    check("reset busy", 64'(busy), 64'd0);
    check("reset frame_done", 64'(frame_done), 64'd0);
    check("reset err", 64'(err), 64'd0);
    check_mem("reset", 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 4; v++) begin
      done_cnt = 0;
      send(vecs[v].key, vecs[v].plain, vecs[v].nbits);
      check($sformatf("vec%0d done count", v), 64'(done_cnt), 64'(vecs[v].exp_done));
      check($sformatf("vec%0d busy", v), 64'(busy), 64'd0);
      check($sformatf("vec%0d err", v), 64'(err), 64'(vecs[v].exp_err));
      check_mem($sformatf("vec%0d", v), vecs[v].exp_mem);
    end

    // Reset in the middle of a frame after 30 bits.
    done_cnt = 0;
    for (int j = 0; j < 30; j++) begin
      @(negedge clk);
      ena_in = 1'b1; key = 1'b0; data_enc = (j % 3 == 0);
    end
    @(negedge clk);
    check("busy mid-frame", 64'(busy), 64'd1);
    #1 rst_n = 1'b0; ena_in = 1'b0;
    #1;
    check("midreset busy", 64'(busy), 64'd0);
    check("midreset err", 64'(err), 64'd0);
    check_mem("midreset", 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check("midreset no done", 64'(done_cnt), 64'd0);
    send(1'b0, 64'h0F1E2D3C4B5A6978, 64);
    check("post-reset done count", 64'(done_cnt), 64'd1);
    check_mem("post-reset", 64'h0F1E2D3C4B5A6978);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
